// File: rtl/clint_irq_pkg.sv
// Shared types and constants for the CLINT interrupt sequencer.
// Bit positions follow the RISC-V mip/mie layout, compressed to three bits.
package clint_irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  localparam logic [3:0] CAUSE_MSI = 4'd3;
  localparam logic [3:0] CAUSE_MTI = 4'd7;
  localparam logic [3:0] CAUSE_MEI = 4'd11;

  localparam int MSIP_BIT = 0;
  localparam int MTIP_BIT = 1;
  localparam int MEIP_BIT = 2;

  // True while the source behind a latched cause code is still eligible.
  function automatic logic cause_eligible(input logic [3:0] cause,
                                          input logic [2:0] elig);
    logic hit;
    hit = 1'b0;
    case (cause)
      CAUSE_MEI: hit = elig[MEIP_BIT];
      CAUSE_MSI: hit = elig[MSIP_BIT];
      CAUSE_MTI: hit = elig[MTIP_BIT];
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/clint_irq_if.sv
// Request/acknowledge link between the interrupt sequencer and the core trap logic.
interface clint_irq_if;
  import clint_irq_pkg::*;

  logic       irq_req;
  logic [3:0] irq_cause;
  logic       irq_ack;
  logic       mret;

  modport master (
    output irq_req,
    output irq_cause,
    input  irq_ack,
    input  mret
  );

  modport slave (
    input  irq_req,
    input  irq_cause,
    output irq_ack,
    output mret
  );

endinterface

// File: rtl/clint_irq_prio.sv
// Fixed-priority selector: MEI over MSI over MTI, as the privileged spec orders them.
module clint_irq_prio
  import clint_irq_pkg::*;
(
  input  logic [2:0] elig_i,
  output logic       valid_o,
  output logic [3:0] cause_o
);

  always_comb begin
    valid_o = |elig_i;
    cause_o = '0;
    if (elig_i[MEIP_BIT]) begin
      cause_o = CAUSE_MEI;
    end else if (elig_i[MSIP_BIT]) begin
      cause_o = CAUSE_MSI;
    end else if (elig_i[MTIP_BIT]) begin
      cause_o = CAUSE_MTI;
    end
  end

endmodule

// File: rtl/clint_irq_ctrl.sv
// Latches CLINT/PLIC interrupt sources into mip and delivers them one at a time to the core.
//   state   | meaning
//   IDLE    | nothing offered; picks the top eligible cause
//   REQ     | irq_req high, cause frozen until ack or withdrawal
//   SERVICE | handler running, delivery masked until mret
module clint_irq_ctrl
  import clint_irq_pkg::*;
(
  input  logic            clk,
  input  logic            n_rst,
  input  logic            timer_int_i,
  input  logic            clear_timer_int_i,
  input  logic            soft_int_i,
  input  logic            clear_soft_int_i,
  input  logic            ext_int_i,
  input  logic            mstatus_mie_i,
  input  logic [2:0]      mie_i,
  output logic [2:0]      mip_o,
  output logic            wfi_wake_o,
  clint_irq_if.master     core_if
);

  state_e     state_q, state_d;
  logic [2:0] mip_q, mip_d;
  logic       irq_req_q, irq_req_d;
  logic [3:0] cause_q, cause_d;

  logic [2:0] eligible;
  logic       prio_valid;
  logic [3:0] prio_cause;

  // Clears win over sets so a mtimecmp write racing a crossing leaves mtip low.
  always_comb begin
    mip_d = mip_q;
    if (soft_int_i)        mip_d[MSIP_BIT] = 1'b1;
    if (clear_soft_int_i)  mip_d[MSIP_BIT] = 1'b0;
    if (timer_int_i)       mip_d[MTIP_BIT] = 1'b1;
    if (clear_timer_int_i) mip_d[MTIP_BIT] = 1'b0;
    mip_d[MEIP_BIT] = ext_int_i;
  end

  assign eligible = mip_q & mie_i & {3{mstatus_mie_i}};

  clint_irq_prio u_prio (
    .elig_i  (eligible),
    .valid_o (prio_valid),
    .cause_o (prio_cause)
  );

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      IDLE: begin
        if (prio_valid) begin
          state_d = REQ;
          cause_d = prio_cause;
        end
      end
      REQ: begin
        if (core_if.irq_ack) begin
          state_d = SERVICE;
        end else if (!cause_eligible(cause_q, eligible)) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (core_if.mret) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    irq_req_d = (state_d == REQ);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      mip_q     <= '0;
      irq_req_q <= 1'b0;
      cause_q   <= '0;
    end else begin
      state_q   <= state_d;
      mip_q     <= mip_d;
      irq_req_q <= irq_req_d;
      cause_q   <= cause_d;
    end
  end

  assign core_if.irq_req   = irq_req_q;
  assign core_if.irq_cause = cause_q;
  assign mip_o             = mip_q;
  // Wake ignores the global enable so WFI resumes even with interrupts masked.
  assign wfi_wake_o        = |(mip_q & mie_i);

endmodule

// File: tb/tb_clint_irq_ctrl.sv
// Directed bench for clint_irq_ctrl with a spec-level reference model checked every cycle.
module tb_clint_irq_ctrl;

  logic       clk;
  logic       n_rst;
  logic       timer_int, clear_timer_int, soft_int, clear_soft_int, ext_int;
  logic       mstatus_mie;
  logic [2:0] mie;
  logic [2:0] mip;
  logic       wfi_wake;

  int vectors;
  int miscompares;

  clint_irq_if cif ();

  clint_irq_ctrl dut (
    .clk               (clk),
    .n_rst             (n_rst),
    .timer_int_i       (timer_int),
    .clear_timer_int_i (clear_timer_int),
    .soft_int_i        (soft_int),
    .clear_soft_int_i  (clear_soft_int),
    .ext_int_i         (ext_int),
    .mstatus_mie_i     (mstatus_mie),
    .mie_i             (mie),
    .mip_o             (mip),
    .wfi_wake_o        (wfi_wake),
    .core_if           (cif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase 0 = idle, 1 = requesting, 2 = in handler.
  int         m_phase;
  logic [3:0] m_cause;
  logic [2:0] m_mip;
  logic [2:0] m_elig;
  int         m_top;
  logic       m_still;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_phase = 0;
      m_cause = 4'd0;
      m_mip   = 3'b000;
    end else begin
      m_elig = m_mip & mie & {3{mstatus_mie}};
      if (m_elig[2])      m_top = 11;
      else if (m_elig[0]) m_top = 3;
      else if (m_elig[1]) m_top = 7;
      else                m_top = 0;
      m_still = (m_cause == 4'd11 && m_elig[2]) ||
                (m_cause == 4'd3  && m_elig[0]) ||
                (m_cause == 4'd7  && m_elig[1]);
      if (m_phase == 0) begin
        if (m_top != 0) begin
          m_phase = 1;
          m_cause = 4'(m_top);
        end
      end else if (m_phase == 1) begin
        if (cif.irq_ack)   m_phase = 2;
        else if (!m_still) m_phase = 0;
      end else begin
        if (cif.mret) m_phase = 0;
      end
      if (clear_soft_int)  m_mip[0] = 1'b0;
      else if (soft_int)   m_mip[0] = 1'b1;
      if (clear_timer_int) m_mip[1] = 1'b0;
      else if (timer_int)  m_mip[1] = 1'b1;
      m_mip[2] = ext_int;
    end
  end

  always @(negedge clk) begin
    vectors++;
    if (cif.irq_req !== (m_phase == 1) || cif.irq_cause !== m_cause ||
        mip !== m_mip || wfi_wake !== (|(m_mip & mie))) begin
      miscompares++;
      $display("FAIL model_cmp t=%0t req=%b want %b cause=%0d want %0d mip=%b want %b wake=%b want %b",
               $time, cif.irq_req, (m_phase == 1), cif.irq_cause, m_cause,
               mip, m_mip, wfi_wake, |(m_mip & mie));
    end
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    n_rst = 1'b0;
    timer_int = 0; clear_timer_int = 0; soft_int = 0; clear_soft_int = 0; ext_int = 0;
    mstatus_mie = 0; mie = 3'b000;
    cif.irq_ack = 1'b0;
    cif.mret = 1'b0;
    #3;
    chk("rst_req", 4'(cif.irq_req), 4'd0);
    chk("rst_cause", cif.irq_cause, 4'd0);
    chk("rst_mip", 4'(mip), 4'd0);
    chk("rst_wake", 4'(wfi_wake), 4'd0);
    @(posedge clk); @(posedge clk); #1;
    n_rst = 1'b1;
    mstatus_mie = 1'b1;
    mie = 3'b010;
    tick();

    // Timer delivery
    timer_int = 1; tick(); timer_int = 0;
    chk("tmr_mip", 4'(mip), 4'b0010);
    chk("tmr_req_n1", 4'(cif.irq_req), 4'd0);
    tick();
    chk("tmr_req_n2", 4'(cif.irq_req), 4'd1);
    chk("tmr_cause", cif.irq_cause, 4'd7);
    cif.irq_ack = 1; tick(); cif.irq_ack = 0;
    chk("tmr_ack_drop", 4'(cif.irq_req), 4'd0);
    tick();
    chk("tmr_service_mask", 4'(cif.irq_req), 4'd0);
    cif.mret = 1; tick(); cif.mret = 0;
    chk("tmr_mret_k1", 4'(cif.irq_req), 4'd0);
    tick();
    chk("tmr_mret_k2", 4'(cif.irq_req), 4'd1);
    chk("tmr_mret_cause", cif.irq_cause, 4'd7);
    clear_timer_int = 1; tick(); clear_timer_int = 0;
    tick(); tick();
    chk("tmr_cleanup", 4'(cif.irq_req), 4'd0);

    // Priority
    mie = 3'b111;
    soft_int = 1; ext_int = 1; tick(); soft_int = 0;
    chk("pri_mip", 4'(mip), 4'b0101);
    tick();
    chk("pri_req", 4'(cif.irq_req), 4'd1);
    chk("pri_cause_mei", cif.irq_cause, 4'd11);
    cif.irq_ack = 1; tick(); cif.irq_ack = 0;
    ext_int = 0; tick();
    chk("pri_mip_after", 4'(mip), 4'b0001);
    cif.mret = 1; tick(); cif.mret = 0;
    tick();
    chk("pri_req2", 4'(cif.irq_req), 4'd1);
    chk("pri_cause_msi", cif.irq_cause, 4'd3);
    ext_int = 1; tick(); tick();
    chk("pri_no_preempt", cif.irq_cause, 4'd3);
    chk("pri_still_req", 4'(cif.irq_req), 4'd1);
    clear_soft_int = 1; ext_int = 0; tick(); clear_soft_int = 0;
    tick(); tick();
    chk("pri_cleanup", 4'(cif.irq_req), 4'd0);

    // Set/clear collision
    mie = 3'b010;
    timer_int = 1; clear_timer_int = 1; tick(); timer_int = 0; clear_timer_int = 0;
    chk("col_mip", 4'(mip), 4'd0);
    tick();
    chk("col_req_a", 4'(cif.irq_req), 4'd0);
    tick();
    chk("col_req_b", 4'(cif.irq_req), 4'd0);

    // Withdrawal, then ack racing the clear
    mie = 3'b001;
    soft_int = 1; tick(); soft_int = 0; tick();
    chk("wd_req", 4'(cif.irq_req), 4'd1);
    chk("wd_cause", cif.irq_cause, 4'd3);
    clear_soft_int = 1; tick(); clear_soft_int = 0;
    chk("wd_hold", 4'(cif.irq_req), 4'd1);
    tick();
    chk("wd_withdrawn", 4'(cif.irq_req), 4'd0);
    soft_int = 1; tick(); soft_int = 0; tick();
    chk("wd_req_again", 4'(cif.irq_req), 4'd1);
    clear_soft_int = 1; cif.irq_ack = 1; tick(); clear_soft_int = 0; cif.irq_ack = 0;
    chk("wd_ack_wins", 4'(cif.irq_req), 4'd0);
    soft_int = 1; tick(); soft_int = 0; tick();
    chk("wd_in_service", 4'(cif.irq_req), 4'd0);
    cif.mret = 1; tick(); cif.mret = 0; tick();
    chk("wd_after_mret", 4'(cif.irq_req), 4'd1);
    clear_soft_int = 1; tick(); clear_soft_int = 0;
    tick(); tick();

    // Global mask and wake
    mstatus_mie = 0;
    soft_int = 1; tick(); soft_int = 0; tick();
    chk("mask_req", 4'(cif.irq_req), 4'd0);
    chk("mask_wake", 4'(wfi_wake), 4'd1);
    mstatus_mie = 1; tick();
    chk("unmask_req", 4'(cif.irq_req), 4'd1);
    chk("unmask_cause", cif.irq_cause, 4'd3);
    cif.irq_ack = 1; tick(); cif.irq_ack = 0;
    chk("unmask_ack", 4'(cif.irq_req), 4'd0);

    // Reset mid-SERVICE
    n_rst = 0; #1;
    chk("arst_mip", 4'(mip), 4'd0);
    chk("arst_req", 4'(cif.irq_req), 4'd0);
    chk("arst_cause", cif.irq_cause, 4'd0);
    chk("arst_wake", 4'(wfi_wake), 4'd0);
    #10;
    n_rst = 1;
    tick();
    cif.mret = 1; tick(); cif.mret = 0;
    chk("stray_mret", 4'(cif.irq_req), 4'd0);
    soft_int = 1; tick(); soft_int = 0; tick();
    chk("post_rst_req", 4'(cif.irq_req), 4'd1);
    cif.mret = 1; tick(); cif.mret = 0;
    chk("mret_in_req", 4'(cif.irq_req), 4'd1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/clint_irq_ctrl.md
# clint_irq_ctrl

Interrupt sequencer between the CLINT and the core's trap logic. It latches the CLINT timer and software interrupt pulses, plus the external interrupt level from the PLIC, into machine pending bits. It applies the core's enable bits and fixed RISC-V priority, then delivers one interrupt at a time to the core over a req/ack handshake. It holds off further delivery until the handler returns.

## Interface
Parameters: none.

- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- timer_int  in  1  CLINT one-cycle pulse: mtime crossed mtimecmp
- clear_timer_int  in  1  CLINT pulse: mtimecmp/mtimecmph written
- soft_int  in  1  CLINT pulse: msip written with bit0=1
- clear_soft_int  in  1  CLINT pulse: msip written with bit0=0
- ext_int  in  1  PLIC external interrupt, level
- mstatus_mie  in  1  global machine interrupt enable
- mie  in  3  per-source enables {meie, mtie, msie}
- irq_ack  in  1  core took the trap; one-cycle pulse
- mret  in  1  core executed mret; one-cycle pulse
- irq_req  out  1  interrupt request to core
- irq_cause  out  4  mcause code: 11 MEI, 3 MSI, 7 MTI
- mip  out  3  pending {meip, mtip, msip} for CSR reads
- wfi_wake  out  1  any pending & enabled, ignoring mstatus_mie

## Operation
- Pending bits are registered.
  - msip: set on soft_int, cleared on clear_soft_int.
  - mtip: set on timer_int, cleared on clear_timer_int. Clear wins when both occur in the same cycle.
  - meip: registered copy of ext_int.
- irq_ack does not clear pending. Software clears pending through the CLINT or PLIC.
- eligible = mip & mie & {3{mstatus_mie}}.
- Fixed priority: MEI > MSI > MTI.
- FSM states:
  - IDLE: irq_req=0. If any eligible bit is set, latch the highest-priority cause and go to REQ.
  - REQ: irq_req=1, irq_cause held stable.
    - irq_ack → SERVICE.
    - Else, if the latched source is no longer eligible → IDLE, withdrawing the request.
    - A higher-priority source arriving in REQ does not change irq_cause.
  - SERVICE: irq_req=0, all delivery masked. mret → IDLE.
- irq_ack and withdrawal in the same cycle: ack wins.
- irq_ack outside REQ is ignored. mret outside SERVICE is ignored.
- wfi_wake = |(mip & mie), combinational. It is active in every state.

## Timing
- Reset values: state IDLE, mip=0, irq_req=0, irq_cause=0, wfi_wake=0.
- Source pulse in cycle N → mip bit set in N+1 → irq_req=1 in N+2, provided it is enabled and the FSM is in IDLE.
- irq_req and irq_cause are registered, and are stable for the whole of REQ.
- irq_ack in cycle M → irq_req=0 in M+1.
- mret in cycle K → IDLE in K+1. If an interrupt is still eligible, irq_req=1 again in K+2.
- Back-to-back delivery always has at least one IDLE cycle between REQ phases.
- Asynchronous reset mid-REQ or mid-SERVICE returns every output to its reset value immediately. Pending state is lost.

## Structure
- Package clint_irq_pkg:
  - state enum {IDLE, REQ, SERVICE}.
  - Cause constants CAUSE_MSI=4'd3, CAUSE_MTI=4'd7, CAUSE_MEI=4'd11.
  - Bit indices for the 3-bit mip/mie vectors.
- Sub-module clint_irq_prio: combinational 3-bit eligible vector → valid + 4-bit cause, implementing the fixed priority.

## Test plan
- Timer delivery:
  - Stimulus: mie=3'b010, mstatus_mie=1, timer_int pulse at cycle 0.
  - Response: mip=3'b010 at cycle 1; irq_req=1, irq_cause=7 at cycle 2.
  - Then irq_ack → irq_req=0 next cycle; mret → IDLE; mtip still set → irq_req re-asserts 2 cycles after mret.
- Priority:
  - Stimulus: soft_int and ext_int in the same cycle, all enabled.
  - Response: irq_cause=11; after ack and mret, with ext_int low, irq_cause=3.
- Set/clear collision:
  - Stimulus: timer_int and clear_timer_int in the same cycle.
  - Response: mtip stays 0 and irq_req never asserts.
- Withdrawal:
  - Stimulus: in REQ with cause 3, clear_soft_int arrives before ack.
  - Response: irq_req=0 and state IDLE.
  - Repeat with irq_ack in the same cycle as the clear → SERVICE (ack wins).
- Global mask and wake:
  - Stimulus: mstatus_mie=0, mie=3'b001, soft_int.
  - Response: irq_req stays 0, wfi_wake=1.
  - Then set mstatus_mie=1 → irq_req=1 one cycle later.
- Reset mid-SERVICE:
  - Stimulus: assert n_rst low.
  - Response: mip=0 and irq_req=0 immediately; after release, state IDLE and a stray mret is ignored.
